// File: rtl/instrmem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings,
// the default end-of-program marker and the full-word write enable.
package loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [3:0]  WE_ALL            = 4'b1111;

endpackage

// File: rtl/instrmem_loader_byte_assembler.sv
// Big-endian byte-to-word assembler: shifts received bytes in and flags the
// completed word in the same cycle as its last byte is accepted.
module byte_assembler #(
    parameter int NB_BYTE = 8,
    parameter int NB_WORD = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_byte_valid,
    input  logic [NB_BYTE-1:0] i_byte_data,
    output logic               o_word_valid,
    output logic [NB_WORD-1:0] o_word
);

    // Only the first three bytes need storing; the fourth arrives with word_valid.
    logic [NB_WORD-NB_BYTE-1:0] shift_reg;
    logic [1:0]                 byte_cnt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift_reg <= '0;
            byte_cnt  <= 2'd0;
        end else if (i_clear) begin
            shift_reg <= '0;
            byte_cnt  <= 2'd0;
        end else if (i_byte_valid) begin
            shift_reg <= {shift_reg[NB_WORD-2*NB_BYTE-1:0], i_byte_data};
            byte_cnt  <= byte_cnt + 2'd1;
        end
    end

    assign o_word_valid = i_byte_valid && !i_clear && (byte_cnt == 2'd3);
    assign o_word       = {shift_reg, i_byte_data};

endmodule

// File: rtl/instrmem_loader.sv
// Loads a program received byte-by-byte into instruction memory, one word per
// write, and releases the CPU (o_done) once the HALT word has been stored.
module instrmem_loader
    import loader_pkg::*;
#(
    parameter int                 NB_INSTR  = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 NB_ADDR   = 16,
    parameter int                 N_WORDS   = 2048,
    parameter logic [NB_INSTR-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic [NB_ADDR-1:0]  o_instrmem_addr,
    output logic [NB_INSTR-1:0] o_instrmem_data,
    output logic [3:0]          o_instrmem_we,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [NB_ADDR-1:0]  o_word_count
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);

    logic [2:0]          state;
    logic                busy_state;
    logic                accept_byte;
    logic                clear_asm;
    logic                word_valid;
    logic [NB_INSTR-1:0] word;

    assign busy_state  = (state == ST_RECV) || (state == ST_WRITE);
    // A start pulse wins over a coincident byte, and idle states hold the assembler empty.
    assign accept_byte = i_rx_valid && busy_state && !i_start;
    assign clear_asm   = i_start || !busy_state;

    byte_assembler #(
        .NB_BYTE (NB_BYTE),
        .NB_WORD (NB_INSTR)
    ) u_byte_assembler (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (clear_asm),
        .i_byte_valid (accept_byte),
        .i_byte_data  (i_rx_data),
        .o_word_valid (word_valid),
        .o_word       (word)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state           <= ST_IDLE;
            o_instrmem_addr <= '0;
            o_instrmem_data <= '0;
            o_word_count    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        state           <= ST_RECV;
                        o_instrmem_addr <= '0;
                        o_word_count    <= '0;
                    end
                end
                ST_RECV: begin
                    if (i_start) begin
                        o_instrmem_addr <= '0;
                        o_word_count    <= '0;
                    end else if (word_valid) begin
                        o_instrmem_data <= word;
                        state           <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The write strobe is already out this cycle; a restart only redirects what follows.
                    if (i_start) begin
                        state           <= ST_RECV;
                        o_instrmem_addr <= '0;
                        o_word_count    <= '0;
                    end else begin
                        o_word_count <= o_word_count + NB_ADDR'(1);
                        if (o_instrmem_data == HALT_WORD) begin
                            state <= ST_DONE;
                        end else if (o_instrmem_addr == LAST_ADDR) begin
                            state <= ST_ERROR;
                        end else begin
                            o_instrmem_addr <= o_instrmem_addr + NB_ADDR'(1);
                            state           <= ST_RECV;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_instrmem_we = (state == ST_WRITE) ? WE_ALL : 4'b0000;
    assign o_busy        = busy_state;
    assign o_done        = (state == ST_DONE);
    assign o_error       = (state == ST_ERROR);

endmodule

// File: tb/tb_instrmem_loader.sv
// Directed bench for instrmem_loader with a 4-word memory so overflow is reachable;
// a negedge monitor records every write strobe for later comparison.
module tb_instrmem_loader;

    logic        clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [15:0] o_instrmem_addr;
    logic [31:0] o_instrmem_data;
    logic [3:0]  o_instrmem_we;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [15:0] o_word_count;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_we_q[$];

    typedef struct {
        logic        start;
        logic [31:0] word;
        logic [15:0] exp_addr;
        logic        exp_done;
        logic [15:0] exp_wc;
    } vec_t;

    vec_t vecs[6];

    always #5 clock = ~clock;

    instrmem_loader #(
        .N_WORDS (4)
    ) dut (
        .i_clock         (i_reset === 1'bx ? 1'b0 : clock),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_rx_data       (i_rx_data),
        .i_rx_valid      (i_rx_valid),
        .o_instrmem_addr (o_instrmem_addr),
        .o_instrmem_data (o_instrmem_data),
        .o_instrmem_we   (o_instrmem_we),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error),
        .o_word_count    (o_word_count)
    );

    always @(negedge clock) begin
        if (o_instrmem_we != 4'b0000) begin
            wr_addr_q.push_back(o_instrmem_addr);
            wr_data_q.push_back(o_instrmem_data);
            wr_we_q.push_back(o_instrmem_we);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clock);
        i_rx_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[31-8*i -: 8];
            send_byte(b);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0;
    endtask

    task automatic expect_write(input string name, input logic [15:0] addr, input logic [31:0] data);
        if (wr_addr_q.size() == 0) begin
            check_output({name, "_present"}, 32'(wr_addr_q.size()), 32'd1);
        end else begin
            check_output({name, "_addr"}, 32'(wr_addr_q.pop_front()), 32'(addr));
            check_output({name, "_data"}, wr_data_q.pop_front(), data);
            check_output({name, "_we"}, 32'(wr_we_q.pop_front()), 32'hF);
        end
    endtask

    task automatic expect_no_writes(input string name);
        check_output(name, 32'(wr_addr_q.size()), 32'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_we_q.delete();
    endtask

    initial begin
        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;

        vecs[0] = '{1'b1, 32'h0000_0001, 16'd0, 1'b0, 16'd1};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 16'd1, 1'b1, 16'd2};
        vecs[2] = '{1'b1, 32'hA5A5_0F0F, 16'd0, 1'b0, 16'd1};
        vecs[3] = '{1'b0, 32'hDEAD_BEEF, 16'd1, 1'b0, 16'd2};
        vecs[4] = '{1'b0, 32'hCAFE_F00D, 16'd2, 1'b0, 16'd3};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 16'd3, 1'b1, 16'd4};

        idle(3);
        check_output("rst_addr", 32'(o_instrmem_addr), 32'd0);
        check_output("rst_data", o_instrmem_data, 32'd0);
        check_output("rst_we", 32'(o_instrmem_we), 32'd0);
        check_output("rst_busy", 32'(o_busy), 32'd0);
        check_output("rst_done", 32'(o_done), 32'd0);
        check_output("rst_error", 32'(o_error), 32'd0);
        check_output("rst_wc", 32'(o_word_count), 32'd0);
        @(negedge clock);
        i_reset = 1'b1;

        // Bytes in IDLE are ignored.
        apply_stimulus(32'h1234_5678);
        idle(2);
        expect_no_writes("idle_ignores_bytes");

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].start) pulse_start();
            apply_stimulus(vecs[i].word);
            idle(2);
            expect_write($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].word);
            check_output($sformatf("vec%0d_done", i), 32'(o_done), 32'(vecs[i].exp_done));
            check_output($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(!vecs[i].exp_done));
            check_output($sformatf("vec%0d_error", i), 32'(o_error), 32'd0);
            check_output($sformatf("vec%0d_wc", i), 32'(o_word_count), 32'(vecs[i].exp_wc));
        end

        apply_stimulus(32'h0BAD_0BAD);
        idle(2);
        expect_no_writes("done_ignores_bytes");

        // Restart from DONE: done falls on the start edge itself.
        @(negedge clock);
        i_start = 1'b1;
        @(posedge clock);
        #1;
        check_output("restart_done_drop", 32'(o_done), 32'd0);
        check_output("restart_busy", 32'(o_busy), 32'd1);
        check_output("restart_wc", 32'(o_word_count), 32'd0);
        @(negedge clock);
        i_start = 1'b0;

        // Back-to-back bytes: the fifth byte arrives during the WRITE cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            i_rx_data  = 8'(8'h11 * (i + 1));
            i_rx_valid = 1'b1;
        end
        @(negedge clock);
        i_rx_valid = 1'b0;
        apply_stimulus(32'hFFFF_FFFF);
        idle(2);
        expect_write("b2b_w0", 16'd0, 32'h1122_3344);
        expect_write("b2b_w1", 16'd1, 32'h5566_7788);
        expect_write("b2b_halt", 16'd2, 32'hFFFF_FFFF);
        check_output("b2b_done", 32'(o_done), 32'd1);
        check_output("b2b_wc", 32'(o_word_count), 32'd3);

        // Overflow: four non-HALT words fill the memory.
        pulse_start();
        apply_stimulus(32'h0102_0304);
        apply_stimulus(32'h0506_0708);
        apply_stimulus(32'h090A_0B0C);
        apply_stimulus(32'h0D0E_0F10);
        idle(2);
        expect_write("ovf_w0", 16'd0, 32'h0102_0304);
        expect_write("ovf_w1", 16'd1, 32'h0506_0708);
        expect_write("ovf_w2", 16'd2, 32'h090A_0B0C);
        expect_write("ovf_w3", 16'd3, 32'h0D0E_0F10);
        check_output("ovf_error", 32'(o_error), 32'd1);
        check_output("ovf_done", 32'(o_done), 32'd0);
        check_output("ovf_busy", 32'(o_busy), 32'd0);
        check_output("ovf_wc", 32'(o_word_count), 32'd4);
        apply_stimulus(32'h1111_1111);
        idle(2);
        expect_no_writes("error_ignores_bytes");

        // Restart mid-word, with a byte coincident with the start pulse.
        pulse_start();
        check_output("err_cleared", 32'(o_error), 32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clock);
        i_start    = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h99;
        @(negedge clock);
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        apply_stimulus(32'h1234_5678);
        idle(2);
        expect_write("restart_w0", 16'd0, 32'h1234_5678);
        expect_no_writes("restart_single_write");
        check_output("restart_wc1", 32'(o_word_count), 32'd1);

        // Asynchronous reset in the middle of a load.
        pulse_start();
        apply_stimulus(32'hCAFE_BABE);
        send_byte(8'h01);
        send_byte(8'h02);
        expect_write("prerst_w0", 16'd0, 32'hCAFE_BABE);
        @(negedge clock);
        #2;
        i_reset = 1'b0;
        #1;
        check_output("arst_addr", 32'(o_instrmem_addr), 32'd0);
        check_output("arst_data", o_instrmem_data, 32'd0);
        check_output("arst_we", 32'(o_instrmem_we), 32'd0);
        check_output("arst_busy", 32'(o_busy), 32'd0);
        check_output("arst_done", 32'(o_done), 32'd0);
        check_output("arst_error", 32'(o_error), 32'd0);
        check_output("arst_wc", 32'(o_word_count), 32'd0);
        @(negedge clock);
        i_reset = 1'b1;
        apply_stimulus(32'h5555_5555);
        idle(2);
        expect_no_writes("postrst_no_writes");
        check_output("postrst_busy", 32'(o_busy), 32'd0);
        pulse_start();
        apply_stimulus(32'h8765_4321);
        idle(2);
        expect_write("postrst_w0", 16'd0, 32'h8765_4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
